spi_frame_ctrl: RTL

SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

---
 rtl/spi_frame_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/spi_frame_ctrl.sv
// SPI (mode 0, MSB first) frame controller: receives opcode + two operands, issues them to an FPU, returns the result on miso.
// Optional WAIT timeout (qNaN result + sticky flag) is enabled by defining SPI_FRAME_WAIT_TIMEOUT_EN.
module spi_frame_ctrl #(
    parameter int DATA_W         = 16,
    parameter int OPC_W          = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cs_active,
    input  logic              cs_fall,
    input  logic              cs_rise,
    input  logic              sclk_rise,
    input  logic              sclk_fall,
    input  logic              mosi,
    output logic              miso,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [OPC_W-1:0]  opcode,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              timeout
);

    typedef enum logic [2:0] {IDLE, CMD, OPA, OPB, ISSUE, WAIT, TX, DONE} state_t;

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] OPC_LAST  = CNT_W'(OPC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] shift_in;
    logic [DATA_W-1:0] shift_next;
    logic [DATA_W-1:0] tx_shift;
    logic              rx_edge;
    logic              tx_edge;

`ifdef SPI_FRAME_WAIT_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WC_W-1:0]   WAIT_LAST = WC_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_W-1:0] QNAN      = DATA_W'(16'h7E00);
    logic [WC_W-1:0] wait_cnt;
`else
    assign timeout = 1'b0;
`endif

    // SCLK strobes only count while the chip is selected
    assign rx_edge    = sclk_rise & cs_active;
    assign tx_edge    = sclk_fall & cs_active;
    assign shift_next = {shift_in, mosi};
    assign busy       = (state != IDLE);
    assign miso       = (state == TX) & tx_shift[DATA_W-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_in  <= '0;
            tx_shift  <= '0;
            opcode    <= '0;
            operand_a <= '0;
            operand_b <= '0;
            op_valid  <= 1'b0;
`ifdef SPI_FRAME_WAIT_TIMEOUT_EN
            wait_cnt  <= '0;
            timeout   <= 1'b0;
`endif
        end else if (cs_rise) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            op_valid <= 1'b0;
        end else if (cs_fall) begin
            state    <= CMD;
            bit_cnt  <= '0;
            shift_in <= '0;
            op_valid <= 1'b0;
`ifdef SPI_FRAME_WAIT_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
        end else begin
            case (state)
                CMD: if (rx_edge) begin
                    shift_in <= shift_next[DATA_W-2:0];
                    if (bit_cnt == OPC_LAST) begin
                        opcode  <= shift_next[OPC_W-1:0];
                        bit_cnt <= '0;
                        state   <= OPA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                OPA: if (rx_edge) begin
                    shift_in <= shift_next[DATA_W-2:0];
                    if (bit_cnt == DATA_LAST) begin
                        operand_a <= shift_next;
                        bit_cnt   <= '0;
                        state     <= OPB;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                OPB: if (rx_edge) begin
                    shift_in <= shift_next[DATA_W-2:0];
                    if (bit_cnt == DATA_LAST) begin
                        operand_b <= shift_next;
                        bit_cnt   <= '0;
                        op_valid  <= 1'b1;
                        state     <= ISSUE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ISSUE: if (op_ready) begin
                    op_valid <= 1'b0;
                    state    <= WAIT;
`ifdef SPI_FRAME_WAIT_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (res_valid) begin
                        tx_shift <= res_data;
                        bit_cnt  <= '0;
                        state    <= TX;
                    end
`ifdef SPI_FRAME_WAIT_TIMEOUT_EN
                    // No result in time: answer with a quiet NaN instead of hanging the master
                    else if (wait_cnt == WAIT_LAST) begin
                        tx_shift <= QNAN;
                        timeout  <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= TX;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                TX: if (tx_edge) begin
                    tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                        state   <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                IDLE, DONE: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
